// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, the
// matrix-position-to-key map and the BCD-to-binary converter states.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_CLR  = 4'd10;
  localparam logic [3:0] KEY_BSP  = 4'd11;
  localparam logic [3:0] KEY_ENT  = 4'd12;
  localparam logic [3:0] KEY_NONE = 4'd15;

  // Physical layout (rows top to bottom, columns left to right):
  //   1 2 3 A      A = backspace
  //   4 5 6 B      * = clear, # = enter
  //   7 8 9 C      B, C, D are unused
  //   * 0 # D
  // Index is col*4 + row.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = KEY_1;
      4'd1:    key_map = KEY_4;
      4'd2:    key_map = KEY_7;
      4'd3:    key_map = KEY_CLR;
      4'd4:    key_map = KEY_2;
      4'd5:    key_map = KEY_5;
      4'd6:    key_map = KEY_8;
      4'd7:    key_map = KEY_0;
      4'd8:    key_map = KEY_3;
      4'd9:    key_map = KEY_6;
      4'd10:   key_map = KEY_9;
      4'd11:   key_map = KEY_ENT;
      4'd12:   key_map = KEY_BSP;
      default: key_map = KEY_NONE;
    endcase
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

endpackage

// File: rtl/keypad_scanner.sv
// Matrix scanner: row synchronizer, column divider/driver, 16-bit scan
// snapshot and press/release debounce. Emits a registered key code and a
// one-cycle valid pulse per accepted press.
// Optional: define KEYPAD_REPEAT_EN to auto-repeat held digit keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 5,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_RATE    = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n_i,
  output logic [3:0] col_n_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LIMIT = DB_W'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [15:0]      snap_q;
  logic             held_q, held_d;
  logic [3:0]       cand_q, cand_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_run_q, rep_run_d;
`endif

  logic        tick, scan_done, scan_none, scan_single;
  logic [15:0] scan_w;
  logic [3:0]  scan_idx;

  assign tick      = (div_q == DIV_LAST);
  assign scan_done = tick && (col_q == 2'd3);
  // Full scan as it will look once column 3 is stored this cycle.
  assign scan_w      = {~row_sync_q, snap_q[11:0]};
  assign scan_none   = (scan_w == 16'd0);
  assign scan_single = !scan_none && ((scan_w & (scan_w - 16'd1)) == 16'd0);
  assign col_n_o     = ~(4'b0001 << col_q);
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;

  // Synchronize rows, divide the clock and capture one column per tick.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_q      <= 2'd0;
      snap_q     <= 16'd0;
    end else begin
      row_meta_q <= row_n_i;
      row_sync_q <= row_meta_q;
      if (tick) begin
        div_q                    <= '0;
        snap_q[{col_q, 2'b00} +: 4] <= ~row_sync_q;
        col_q                    <= col_q + 2'd1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

  // Locate the pressed key in a single-key scan.
  always_comb begin
    scan_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan_w[i]) scan_idx = 4'(i);
    end
  end

  // Debounce next-state: accept a stable single key, release on stable none.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    held_d      = held_q;
    cand_d      = cand_q;
    db_cnt_d    = db_cnt_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_run_d   = rep_run_q;
`endif
    if (scan_done) begin
      if (!held_q) begin
        if (scan_single) begin
          if (scan_idx == cand_q) begin
            db_cnt_d = db_cnt_q + 1'b1;
          end else begin
            cand_d   = scan_idx;
            db_cnt_d = DB_W'(1);
          end
          if (db_cnt_d == DB_LIMIT) begin
            key_valid_d = 1'b1;
            held_d      = 1'b1;
            db_cnt_d    = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
            rep_run_d   = 1'b0;
`endif
          end
        end else begin
          db_cnt_d = '0;
        end
      end else begin
        if (scan_none) begin
          db_cnt_d = db_cnt_q + 1'b1;
          if (db_cnt_d == DB_LIMIT) begin
            held_d   = 1'b0;
            db_cnt_d = '0;
          end
        end else begin
          db_cnt_d = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (scan_single && (scan_idx == cand_q) && (key_map(cand_q) <= KEY_9)) begin
          rep_cnt_d = rep_cnt_q + 1'b1;
          if ((!rep_run_q && rep_cnt_d == REP_DELAY) || (rep_run_q && rep_cnt_d == REP_RATE)) begin
            key_valid_d = 1'b1;
            rep_cnt_d   = '0;
            rep_run_d   = 1'b1;
          end
        end else begin
          rep_cnt_d = '0;
          rep_run_d = 1'b0;
        end
`endif
      end
    end
    key_code_d = key_valid_d ? key_map(cand_d) : key_code_q;
  end

  // Debounce state and registered key outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_q      <= 1'b0;
      cand_q      <= 4'd0;
      db_cnt_q    <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_run_q   <= 1'b0;
`endif
    end else begin
      held_q      <= held_d;
      cand_q      <= cand_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_run_q   <= rep_run_d;
`endif
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry top level: four-digit BCD entry buffer edited by accepted
// keys, and a multiply-add FSM that converts the buffer to binary on Enter.
// Optional: define KEYPAD_REPEAT_EN to auto-repeat held digit keys.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 12000,
  parameter int DEBOUNCE_SCANS = 5,
  parameter int REPEAT_DELAY   = 125,
  parameter int REPEAT_RATE    = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] bcd,
  output logic [15:0] value,
  output logic        value_valid
);

  conv_state_e state_q, state_d;
  logic [15:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        entered_q, entered_d;
  logic [15:0] conv_q, conv_d;
  logic [15:0] acc_q, acc_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] value_q, value_d;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_RATE   (REPEAT_RATE)
  ) u_scanner (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n_i    (row_n),
    .col_n_o    (col_n),
    .key_code_o (key_code),
    .key_valid_o(key_valid)
  );

  assign bcd         = bcd_q;
  assign value       = value_q;
  // value is loaded on the edge into DONE, so the pulse lines up with it.
  assign value_valid = (state_q == ST_DONE);

  // Conversion steps and buffer edits from accepted keys.
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    entered_d = entered_q;
    conv_d    = conv_q;
    acc_d     = acc_q;
    step_d    = step_q;
    value_d   = value_q;

    case (state_q)
      ST_CONV: begin
        // acc*10 + digit, thousands digit first from a private copy.
        acc_d  = (acc_q << 3) + (acc_q << 1) + {12'd0, conv_q[15:12]};
        conv_d = conv_q << 4;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          value_d = acc_d;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        entered_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (key_valid) begin
      if (key_code <= KEY_9) begin
        if (entered_q) begin
          bcd_d     = {12'd0, key_code};
          cnt_d     = 3'd1;
          entered_d = 1'b0;
        end else if (cnt_q < 3'd4) begin
          bcd_d = {bcd_q[11:0], key_code};
          cnt_d = cnt_q + 3'd1;
        end
      end else if (key_code == KEY_BSP) begin
        bcd_d     = bcd_q >> 4;
        cnt_d     = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
        entered_d = 1'b0;
      end else if (key_code == KEY_CLR) begin
        bcd_d     = 16'd0;
        cnt_d     = 3'd0;
        entered_d = 1'b0;
      end else if (key_code == KEY_ENT && state_q == ST_IDLE) begin
        conv_d  = bcd_q;
        acc_d   = 16'd0;
        step_d  = 2'd0;
        state_d = ST_CONV;
      end
    end
  end

  // Buffer and converter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bcd_q     <= 16'd0;
      cnt_q     <= 3'd0;
      entered_q <= 1'b0;
      conv_q    <= 16'd0;
      acc_q     <= 16'd0;
      step_q    <= 2'd0;
      value_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      entered_q <= entered_d;
      conv_q    <= conv_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      value_q   <= value_d;
    end
  end

endmodule
